// File: rtl/multicycle_ctrl_fsm_if.sv
// Control bundle between the multicycle control FSM and the datapath.
// The master side (the FSM) reads the instruction opcode and drives every
// datapath select and write enable; the slave side is the datapath.
interface multicycle_ctrl_fsm_if #(
    parameter int OP_WIDTH = 6
);
    logic [OP_WIDTH-1:0] Opcode;
    logic                IorD;
    logic                MemWrite;
    logic                IRWrite;
    logic                RegDst;
    logic                MemtoReg;
    logic                RegWrite;
    logic                ALUSrcA;
    logic [1:0]          ALUSrcB;
    logic [1:0]          ALUOp;
    logic [1:0]          PCSrc;
    logic                PCWrite;
    logic                Beq;
    logic                Bne;
    logic                Instr_Done;
    logic                Illegal_Op;

    modport master (
        input  Opcode,
        output IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite,
        output ALUSrcA, ALUSrcB, ALUOp, PCSrc, PCWrite, Beq, Bne,
        output Instr_Done, Illegal_Op
    );

    modport slave (
        output Opcode,
        input  IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite,
        input  ALUSrcA, ALUSrcB, ALUOp, PCSrc, PCWrite, Beq, Bne,
        input  Instr_Done, Illegal_Op
    );
endinterface

// File: rtl/multicycle_ctrl_fsm.sv
// Main control state machine of the multicycle MIPS core.
// Moore machine: every output is a flop loaded from the decode of the next
// state and the next latched opcode, so the Opcode input never reaches an
// output combinationally. Reset is asynchronous and clears all outputs at once,
// which aborts any instruction in flight before its write can happen.
module multicycle_ctrl_fsm #(
    parameter int OP_WIDTH = 6
) (
    input  logic                 clk,
    input  logic                 reset,
    multicycle_ctrl_fsm_if.master bus
);
    typedef enum logic [3:0] {
        IDLE    = 4'd0,
        FETCH   = 4'd1,
        DECODE  = 4'd2,
        MEM_ADR = 4'd3,
        MEM_RD  = 4'd4,
        MEM_WB  = 4'd5,
        MEM_WR  = 4'd6,
        EXECUTE = 4'd7,
        ALU_WB  = 4'd8,
        BRANCH  = 4'd9,
        ADDI_EX = 4'd10,
        ADDI_WB = 4'd11,
        JUMP    = 4'd12
    } state_t;

    typedef struct packed {
        logic       iord;
        logic       mem_write;
        logic       ir_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_src;
        logic       pc_write;
        logic       beq;
        logic       bne;
        logic       instr_done;
    } ctrl_t;

    localparam logic [OP_WIDTH-1:0] OP_RTYPE = OP_WIDTH'('h00);
    localparam logic [OP_WIDTH-1:0] OP_J     = OP_WIDTH'('h02);
    localparam logic [OP_WIDTH-1:0] OP_BEQ   = OP_WIDTH'('h04);
    localparam logic [OP_WIDTH-1:0] OP_BNE   = OP_WIDTH'('h05);
    localparam logic [OP_WIDTH-1:0] OP_ADDI  = OP_WIDTH'('h08);
    localparam logic [OP_WIDTH-1:0] OP_LW    = OP_WIDTH'('h23);
    localparam logic [OP_WIDTH-1:0] OP_SW    = OP_WIDTH'('h2B);

    state_t              state_reg;
    state_t              state_next;
    logic [OP_WIDTH-1:0] op_reg;
    logic [OP_WIDTH-1:0] op_next;
    ctrl_t               ctrl_reg;
    ctrl_t               ctrl_next;
    logic                illegal_reg;
    logic                illegal_hit;

    // Output pattern of each state; IDLE and unused encodings decode to all zeros.
    function automatic ctrl_t decode_ctrl(input state_t st, input logic [OP_WIDTH-1:0] op);
        ctrl_t c;
        c = '0;
        case (st)
            FETCH: begin
                c.ir_write  = 1'b1;
                c.alu_src_b = 2'b01;
                c.pc_write  = 1'b1;
            end
            DECODE: begin
                c.alu_src_b = 2'b11;
            end
            MEM_ADR, ADDI_EX: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = 2'b10;
            end
            MEM_RD: begin
                c.iord = 1'b1;
            end
            MEM_WB: begin
                c.mem_to_reg = 1'b1;
                c.reg_write  = 1'b1;
                c.instr_done = 1'b1;
            end
            MEM_WR: begin
                c.iord       = 1'b1;
                c.mem_write  = 1'b1;
                c.instr_done = 1'b1;
            end
            EXECUTE: begin
                c.alu_src_a = 1'b1;
                c.alu_op    = 2'b10;
            end
            ALU_WB: begin
                c.reg_dst    = 1'b1;
                c.reg_write  = 1'b1;
                c.instr_done = 1'b1;
            end
            BRANCH: begin
                // PC is only updated through the branch-condition block here.
                c.alu_src_a  = 1'b1;
                c.pc_src     = 2'b01;
                c.instr_done = 1'b1;
                if (op == OP_BEQ) begin
                    c.beq    = 1'b1;
                    c.alu_op = 2'b01;
                end else if (op == OP_BNE) begin
                    c.bne    = 1'b1;
                    c.alu_op = 2'b11;
                end
            end
            ADDI_WB: begin
                c.reg_write  = 1'b1;
                c.instr_done = 1'b1;
            end
            JUMP: begin
                c.pc_src     = 2'b10;
                c.pc_write   = 1'b1;
                c.instr_done = 1'b1;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

    // Next-state logic; the opcode is captured only while in DECODE.
    always_comb begin
        state_next  = FETCH;
        op_next     = op_reg;
        illegal_hit = 1'b0;
        case (state_reg)
            IDLE:   state_next = FETCH;
            FETCH:  state_next = DECODE;
            DECODE: begin
                op_next = bus.Opcode;
                case (bus.Opcode)
                    OP_LW, OP_SW:    state_next = MEM_ADR;
                    OP_RTYPE:        state_next = EXECUTE;
                    OP_BEQ, OP_BNE:  state_next = BRANCH;
                    OP_ADDI:         state_next = ADDI_EX;
                    OP_J:            state_next = JUMP;
                    default: begin
                        state_next  = FETCH;
                        illegal_hit = 1'b1;
                    end
                endcase
            end
            MEM_ADR: state_next = (op_reg == OP_LW) ? MEM_RD : MEM_WR;
            MEM_RD:  state_next = MEM_WB;
            EXECUTE: state_next = ALU_WB;
            ADDI_EX: state_next = ADDI_WB;
            default: state_next = FETCH;
        endcase

        ctrl_next = decode_ctrl(state_next, op_next);
        // An illegal opcode is only known at the end of DECODE, so its
        // completion pulse is registered and appears with the rising
        // Illegal_Op flag in the following cycle.
        if (illegal_hit) begin
            ctrl_next.instr_done = 1'b1;
        end
    end

    // State, latched opcode, sticky illegal flag and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg   <= IDLE;
            op_reg      <= '0;
            ctrl_reg    <= '0;
            illegal_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            op_reg      <= op_next;
            ctrl_reg    <= ctrl_next;
            illegal_reg <= illegal_reg | illegal_hit;
        end
    end

    assign bus.IorD       = ctrl_reg.iord;
    assign bus.MemWrite   = ctrl_reg.mem_write;
    assign bus.IRWrite    = ctrl_reg.ir_write;
    assign bus.RegDst     = ctrl_reg.reg_dst;
    assign bus.MemtoReg   = ctrl_reg.mem_to_reg;
    assign bus.RegWrite   = ctrl_reg.reg_write;
    assign bus.ALUSrcA    = ctrl_reg.alu_src_a;
    assign bus.ALUSrcB    = ctrl_reg.alu_src_b;
    assign bus.ALUOp      = ctrl_reg.alu_op;
    assign bus.PCSrc      = ctrl_reg.pc_src;
    assign bus.PCWrite    = ctrl_reg.pc_write;
    assign bus.Beq        = ctrl_reg.beq;
    assign bus.Bne        = ctrl_reg.bne;
    assign bus.Instr_Done = ctrl_reg.instr_done;
    assign bus.Illegal_Op = illegal_reg;

endmodule

// File: doc/multicycle_ctrl_fsm.md
Name: multicycle_ctrl_fsm

Overview:
- Main control state machine of the multicycle MIPS core.
- Sits directly upstream of the branch-condition block: drives its Beq/Bne inputs and supplies the unconditional PCWrite that is ORed with its Branch output to form the PC write enable.
- Also drives every datapath mux select and write enable for fetch, decode, memory, ALU, branch and jump sequences.

Parameters:
- OP_WIDTH, 6, width of the opcode field taken from the instruction register.

Ports:
- clk  input  1  system clock, all state changes on rising edge.
- reset  input  1  asynchronous, active-low reset.
- Opcode  input  OP_WIDTH  instruction opcode from the instruction register; valid from DECODE onward.
- IorD  output  1  memory address select: 0 = PC, 1 = ALUOut.
- MemWrite  output  1  data memory write enable.
- IRWrite  output  1  instruction register load.
- RegDst  output  1  write register select: 0 = rt, 1 = rd.
- MemtoReg  output  1  register write data select: 0 = ALUOut, 1 = memory data.
- RegWrite  output  1  register file write enable.
- ALUSrcA  output  1  ALU A select: 0 = PC, 1 = rs.
- ALUSrcB  output  2  ALU B select: 00 = rt, 01 = constant 4, 10 = sign-extended immediate, 11 = immediate shifted left by 2.
- ALUOp  output  2  00 = add, 01 = equality compare (flag = 1 if equal), 10 = funct decode, 11 = inequality compare (flag = 1 if not equal).
- PCSrc  output  2  next-PC select: 00 = ALU result, 01 = ALUOut (branch target), 10 = jump address.
- PCWrite  output  1  unconditional PC write.
- Beq  output  1  beq in progress; goes to branch-condition block.
- Bne  output  1  bne in progress; goes to branch-condition block.
- Instr_Done  output  1  one-cycle pulse in the last state of each instruction.
- Illegal_Op  output  1  sticky flag: an unsupported opcode was decoded.

Behaviour:
- Moore machine.
  - 4-bit registered state.
  - Outputs are decoded from the current state and the latched opcode only; no combinational path from Opcode to any output.
  - Every output not listed for a state is 0 in that state.
- Reset (reset = 0, async):
  - State goes to IDLE; latched opcode and Illegal_Op go to 0.
  - All outputs are 0 while in reset and in IDLE.
  - IDLE goes to FETCH on the first clock edge after reset releases.
  - Reset mid-instruction aborts the instruction immediately; no partial write completes after reset asserts.
- Per-state outputs and next state:
  - FETCH: IRWrite = 1, ALUSrcB = 01, PCWrite = 1. Next: DECODE.
  - DECODE: ALUSrcB = 11; Opcode is latched. Next state by opcode:
    - 0x23 or 0x2B: MEM_ADR.
    - 0x00: EXECUTE.
    - 0x04 or 0x05: BRANCH.
    - 0x08: ADDI_EX.
    - 0x02: JUMP.
    - Any other opcode: FETCH, with Instr_Done = 1 and Illegal_Op set.
  - MEM_ADR: ALUSrcA = 1, ALUSrcB = 10. Next: MEM_RD if latched opcode = 0x23, else MEM_WR.
  - MEM_RD: IorD = 1. Next: MEM_WB.
  - MEM_WB: MemtoReg = 1, RegWrite = 1, Instr_Done = 1. Next: FETCH.
  - MEM_WR: IorD = 1, MemWrite = 1, Instr_Done = 1. Next: FETCH.
  - EXECUTE: ALUSrcA = 1, ALUOp = 10. Next: ALU_WB.
  - ALU_WB: RegDst = 1, RegWrite = 1, Instr_Done = 1. Next: FETCH.
  - BRANCH: ALUSrcA = 1, PCSrc = 01, Instr_Done = 1. Next: FETCH. Opcode-dependent outputs:
    - Latched opcode 0x04: Beq = 1, ALUOp = 01.
    - Latched opcode 0x05: Bne = 1, ALUOp = 11.
    - PCWrite stays 0; the PC update comes only through the branch-condition block.
  - ADDI_EX: ALUSrcA = 1, ALUSrcB = 10. Next: ADDI_WB.
  - ADDI_WB: RegWrite = 1, Instr_Done = 1. Next: FETCH.
  - JUMP: PCSrc = 10, PCWrite = 1, Instr_Done = 1. Next: FETCH.
- Cycle counts, FETCH through the last state inclusive: lw 5, sw 4, R-type 4, addi 4, beq/bne 3, j 3, illegal 2.
- Invariants:
  - Beq and Bne are never both 1.
  - PCWrite and Beq/Bne are never asserted together.
  - Unused state encodings go to FETCH with all outputs 0.
- Opcode changes after DECODE have no effect.
- Illegal_Op clears only on reset.

Test Plan:
- Reset asserted mid-MEM_RD, released -> all outputs 0 during reset and for one IDLE cycle; FETCH on the next edge with IRWrite = 1, PCWrite = 1, ALUSrcB = 01.
- Opcode 0x23 -> states FETCH, DECODE, MEM_ADR, MEM_RD, MEM_WB; in MEM_WB RegWrite = 1, MemtoReg = 1, RegDst = 0, Instr_Done = 1; FETCH again on cycle 6.
- Opcode 0x2B -> MemWrite = 1 and IorD = 1 only in cycle 4; RegWrite stays 0 throughout.
- Opcode 0x00 then 0x08 back-to-back:
  - R-type: ALUOp = 10 in EXECUTE; RegDst = 1 in ALU_WB.
  - addi: ALUSrcB = 10 in ADDI_EX; RegDst = 0 with RegWrite = 1 in ADDI_WB.
  - Instr_Done pulses on cycles 4 and 8.
- Opcode 0x04, then 0x05 -> in each BRANCH cycle PCSrc = 01 and PCWrite = 0:
  - 0x04: Beq = 1, Bne = 0, ALUOp = 01.
  - 0x05: Bne = 1, Beq = 0, ALUOp = 11.
  - Changing Opcode to 0x00 during BRANCH changes no output.
- Opcode 0x3F, then 0x02 -> 0x3F: DECODE returns to FETCH with Illegal_Op = 1, which stays 1. 0x02: JUMP with PCSrc = 10, PCWrite = 1; Illegal_Op still 1 until reset.
